// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding, bus ACK levels and address helpers.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2cState_t;

  function automatic logic addrMatch(input logic [7:0] addrByte,
                                     input logic [I2C_ADDR_W-1:0] devAddr);
    return addrByte[7:1] == devAddr;
  endfunction

endpackage

// File: rtl/i2c_edge_sync.sv
// SCL/SDA synchroniser with edge detection and START/STOP recognition.
module i2c_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic sclIn,
  input  logic sdaIn,
  output logic sdaSync,
  output logic sclRise,
  output logic sclFall,
  output logic startDet,
  output logic stopDet
);

  logic [SYNC_STAGES-1:0] sclPipe;
  logic [SYNC_STAGES-1:0] sdaPipe;
  logic                   sclPrev;
  logic                   sdaPrev;
  logic                   sclSync;
  logic                   sdaRise;
  logic                   sdaFall;

  // Left unreset so a mid-transfer reset cannot fabricate a bus edge.
  always_ff @(posedge clk) begin
    sclPipe <= {sclPipe[SYNC_STAGES-2:0], sclIn};
    sdaPipe <= {sdaPipe[SYNC_STAGES-2:0], sdaIn};
    sclPrev <= sclPipe[SYNC_STAGES-1];
    sdaPrev <= sdaPipe[SYNC_STAGES-1];
  end

  assign sclSync  = sclPipe[SYNC_STAGES-1];
  assign sdaSync  = sdaPipe[SYNC_STAGES-1];
  assign sclRise  = sclSync & ~sclPrev;
  assign sclFall  = ~sclSync & sclPrev;
  assign sdaRise  = sdaSync & ~sdaPrev;
  assign sdaFall  = ~sdaSync & sdaPrev;
  assign startDet = sdaFall & sclSync & sclPrev;
  assign stopDet  = sdaRise & sclSync & sclPrev;

endmodule

// File: rtl/i2c_slave_frontend.sv
// I2C target byte engine: address match, host-byte deserialiser and read-byte serialiser.
module i2c_slave_frontend
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       sclIn,
  input  logic       sdaIn,
  output logic       sdaOe,
  output logic [7:0] dataOut,
  input  logic [7:0] dataIn,
  output logic       writeEnable,
  output logic       readEnable,
  output logic       rdReq,
  output logic       busy,
  output i2cState_t  stateDbg
);

  logic       sdaSync;
  logic       sclRise;
  logic       sclFall;
  logic       startDet;
  logic       stopDet;
  i2cState_t  state;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg;
  logic [7:0] rxByte;
  logic       wePending;

  i2c_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) edgeSync (
    .clk      (clk),
    .sclIn    (sclIn),
    .sdaIn    (sdaIn),
    .sdaSync  (sdaSync),
    .sclRise  (sclRise),
    .sclFall  (sclFall),
    .startDet (startDet),
    .stopDet  (stopDet)
  );

  assign rxByte   = {shiftReg[6:0], sdaSync};
  assign stateDbg = state;

  // writeEnable and rdReq are single-cycle strobes with no back-pressure:
  // the buffer must accept dataOut / advance past dataIn in the strobe cycle.
  // In the ACK states sdaOe itself tells the first (drive) SCL fall from the second (release).
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= IDLE;
      sdaOe       <= 1'b0;
      dataOut     <= 8'h00;
      writeEnable <= 1'b0;
      readEnable  <= 1'b1;
      rdReq       <= 1'b0;
      busy        <= 1'b0;
      bitCnt      <= 3'd0;
      shiftReg    <= 8'h00;
      wePending   <= 1'b0;
    end else begin
      writeEnable <= wePending;
      wePending   <= 1'b0;
      rdReq       <= 1'b0;
      if (stopDet) begin
        state  <= IDLE;
        sdaOe  <= 1'b0;
        busy   <= 1'b0;
        bitCnt <= 3'd0;
      end else if (startDet) begin
        state  <= ADDR;
        sdaOe  <= 1'b0;
        bitCnt <= 3'd0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (sclRise) begin
            shiftReg <= rxByte;
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              if (addrMatch(rxByte, DEV_ADDR)) begin
                state      <= ADDR_ACK;
                busy       <= 1'b1;
                readEnable <= ~rxByte[0];
              end else begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          ADDR_ACK: if (sclFall) begin
            if (!sdaOe) begin
              sdaOe <= 1'b1;
            end else if (readEnable) begin
              sdaOe  <= 1'b0;
              bitCnt <= 3'd0;
              state  <= WR_BYTE;
            end else begin
              shiftReg <= {dataIn[6:0], 1'b0};
              sdaOe    <= ~dataIn[7];
              rdReq    <= 1'b1;
              bitCnt   <= 3'd0;
              state    <= RD_BYTE;
            end
          end
          WR_BYTE: if (sclRise) begin
            shiftReg <= rxByte;
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              dataOut   <= rxByte;
              wePending <= 1'b1;
              state     <= WR_ACK;
            end
          end
          WR_ACK: if (sclFall) begin
            if (!sdaOe) begin
              sdaOe <= 1'b1;
            end else begin
              sdaOe  <= 1'b0;
              bitCnt <= 3'd0;
              state  <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            if (sclRise) begin
              bitCnt <= bitCnt + 3'd1;
            end else if (sclFall) begin
              if (bitCnt == 3'd0) begin
                sdaOe <= 1'b0;
                state <= RD_ACK;
              end else begin
                sdaOe    <= ~shiftReg[7];
                shiftReg <= {shiftReg[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (sclRise && sdaSync == NACK) begin
              state <= IGNORE;
              sdaOe <= 1'b0;
              busy  <= 1'b0;
            end else if (sclFall) begin
              shiftReg <= {dataIn[6:0], 1'b0};
              sdaOe    <= ~dataIn[7];
              rdReq    <= 1'b1;
              bitCnt   <= 3'd0;
              state    <= RD_BYTE;
            end
          end
          IGNORE: sdaOe <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_frontend.sv
// Directed-plus-random bench for i2c_slave_frontend with an open-drain SDA bus and host-side model.
module tb_i2c_slave_frontend;
  import i2c_pkg::*;

  localparam logic [6:0] DEV = 7'h50;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       hostScl = 1'b1;
  logic       hostSda = 1'b1;
  logic [7:0] dataIn = 8'h00;
  logic       sdaBus;
  logic       sdaOe;
  logic [7:0] dataOut;
  logic       writeEnable;
  logic       readEnable;
  logic       rdReq;
  logic       busy;
  i2cState_t  stateDbg;

  int         nChecks = 0;
  int         nErrors = 0;
  int         rdCount = 0;
  int         overlapCount = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obsWe_q[$];
  logic [7:0] expDataOut = 8'h00;

  assign sdaBus = hostSda & ~sdaOe;

  always #5 clk = ~clk;

  i2c_slave_frontend dut (
    .clk         (clk),
    .resetN      (resetN),
    .sclIn       (hostScl),
    .sdaIn       (sdaBus),
    .sdaOe       (sdaOe),
    .dataOut     (dataOut),
    .dataIn      (dataIn),
    .writeEnable (writeEnable),
    .readEnable  (readEnable),
    .rdReq       (rdReq),
    .busy        (busy),
    .stateDbg    (stateDbg)
  );

  // Strobe monitor: records what the buffer side would see.
  always @(negedge clk) begin
    if (writeEnable) obsWe_q.push_back(dataOut);
    if (rdReq) rdCount++;
    if (writeEnable && rdReq) overlapCount++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SCL period: SDA set mid-low, sampled mid-high; ends mid-low.
  task automatic clockBit(input logic b, output logic s);
    hostSda = b;
    tick(5);
    hostScl = 1'b1;
    tick(5);
    s = sdaBus;
    tick(5);
    hostScl = 1'b0;
    tick(5);
  endtask

  task automatic startCond();
    hostSda = 1'b0;
    tick(10);
    hostScl = 1'b0;
    tick(5);
  endtask

  task automatic repStart();
    hostSda = 1'b1;
    tick(5);
    hostScl = 1'b1;
    tick(10);
    hostSda = 1'b0;
    tick(10);
    hostScl = 1'b0;
    tick(5);
  endtask

  task automatic stopCond();
    hostSda = 1'b0;
    tick(5);
    hostScl = 1'b1;
    tick(10);
    hostSda = 1'b1;
    tick(10);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(b[i], s);
    clockBit(1'b1, s);
    acked = (s == ACK);
  endtask

  task automatic readByte(input logic nack, input logic [7:0] nextIn, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, s);
      b[i] = s;
    end
    dataIn = nextIn;
    clockBit(nack, s);
  endtask

  task automatic drainWrites(input string tag);
    chk({tag, "_we_count"}, 32'(obsWe_q.size()), 32'(exp_q.size()));
    while (obsWe_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_we_data"}, 32'(obsWe_q.pop_front()), 32'(exp_q.pop_front()));
    obsWe_q.delete();
    exp_q.delete();
  endtask

  function automatic logic expAck(input logic [7:0] addrByte);
    return addrByte[7:1] == DEV;
  endfunction

  initial begin
    logic       a;
    logic [7:0] b;
    logic [7:0] r;
    logic [7:0] x;
    logic [7:0] addr;
    int         rd0;
    logic       s;

    // Reset values
    tick(6);
    chk("rst_sdaOe", 32'(sdaOe), 32'd0);
    chk("rst_dataOut", 32'(dataOut), 32'h00);
    chk("rst_we", 32'(writeEnable), 32'd0);
    chk("rst_rdEn", 32'(readEnable), 32'd1);
    chk("rst_rdReq", 32'(rdReq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(stateDbg), 32'(IDLE));
    resetN = 1'b1;
    tick(4);

    // 1: addressed write of 0xA5
    startCond();
    writeByte(8'hA0, a);
    chk("t1_addr_ack", 32'(a), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rdEn_addr", 32'(readEnable), 32'd1);
    exp_q.push_back(8'hA5);
    expDataOut = 8'hA5;
    writeByte(8'hA5, a);
    chk("t1_data_ack", 32'(a), 32'd1);
    chk("t1_rdEn_data", 32'(readEnable), 32'd1);
    stopCond();
    tick(4);
    chk("t1_busy_stop", 32'(busy), 32'd0);
    chk("t1_state_stop", 32'(stateDbg), 32'(IDLE));
    drainWrites("t1");
    chk("t1_dataOut", 32'(dataOut), 32'(expDataOut));

    // 1b: random multi-byte write
    startCond();
    writeByte(8'hA0, a);
    chk("t1b_addr_ack", 32'(a), 32'd1);
    for (int n = 0; n < int'($urandom_range(2, 4)); n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      expDataOut = b;
      writeByte(b, a);
      chk("t1b_data_ack", 32'(a), 32'd1);
    end
    stopCond();
    tick(4);
    drainWrites("t1b");
    chk("t1b_dataOut", 32'(dataOut), 32'(expDataOut));

    // 2: mismatched address is ignored
    startCond();
    writeByte(8'hA2, a);
    chk("t2_addr_nack", 32'(a), 32'd0);
    chk("t2_sdaOe", 32'(sdaOe), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_state", 32'(stateDbg), 32'(IGNORE));
    writeByte(8'($urandom), a);
    chk("t2_data_nack", 32'(a), 32'd0);
    stopCond();
    tick(4);
    drainWrites("t2");

    // 2b: random write addresses, matched or not
    for (int k = 0; k < 4; k++) begin
      addr = ($urandom_range(0, 1) == 1) ? {DEV, 1'b0} : {7'($urandom), 1'b0};
      startCond();
      writeByte(addr, a);
      chk("t2b_addr_ack", 32'(a), 32'(expAck(addr)));
      b = 8'($urandom);
      if (expAck(addr)) begin
        exp_q.push_back(b);
        expDataOut = b;
      end
      writeByte(b, a);
      chk("t2b_data_ack", 32'(a), 32'(expAck(addr)));
      stopCond();
      tick(4);
      drainWrites("t2b");
      chk("t2b_dataOut", 32'(dataOut), 32'(expDataOut));
    end

    // 3: read 0x3C, 0xC3, random, then NACK
    rd0 = rdCount;
    dataIn = 8'h3C;
    startCond();
    writeByte(8'hA1, a);
    chk("t3_addr_ack", 32'(a), 32'd1);
    chk("t3_rdEn", 32'(readEnable), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_rdReq_first", 32'(rdCount - rd0), 32'd1);
    readByte(1'b0, 8'hC3, b);
    chk("t3_byte0", 32'(b), 32'h3C);
    r = 8'($urandom);
    readByte(1'b0, r, b);
    chk("t3_byte1", 32'(b), 32'hC3);
    readByte(1'b1, 8'h00, b);
    chk("t3_byte2", 32'(b), 32'(r));
    tick(2);
    chk("t3_nack_sdaOe", 32'(sdaOe), 32'd0);
    chk("t3_nack_busy", 32'(busy), 32'd0);
    chk("t3_nack_state", 32'(stateDbg), 32'(IGNORE));
    chk("t3_rdReq_total", 32'(rdCount - rd0), 32'd3);
    stopCond();
    tick(4);
    drainWrites("t3");

    // 4: write then repeated START into a read
    startCond();
    writeByte(8'hA0, a);
    chk("t4_addr_ack", 32'(a), 32'd1);
    x = 8'($urandom);
    exp_q.push_back(x);
    expDataOut = x;
    writeByte(x, a);
    chk("t4_data_ack", 32'(a), 32'd1);
    chk("t4_rdEn_write", 32'(readEnable), 32'd1);
    repStart();
    r = 8'($urandom);
    dataIn = r;
    writeByte(8'hA1, a);
    chk("t4_raddr_ack", 32'(a), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_rdEn_read", 32'(readEnable), 32'd0);
    readByte(1'b1, 8'h00, b);
    chk("t4_rd_byte", 32'(b), 32'(r));
    stopCond();
    tick(4);
    drainWrites("t4");
    chk("t4_dataOut", 32'(dataOut), 32'(expDataOut));

    // 6: STOP after 5 bits discards the partial byte
    startCond();
    writeByte(8'hA0, a);
    chk("t6_addr_ack", 32'(a), 32'd1);
    x = 8'($urandom);
    for (int i = 7; i >= 3; i--) clockBit(x[i], s);
    stopCond();
    tick(4);
    chk("t6_state", 32'(stateDbg), 32'(IDLE));
    chk("t6_busy", 32'(busy), 32'd0);
    drainWrites("t6");
    chk("t6_dataOut", 32'(dataOut), 32'(expDataOut));

    // 5: reset during bit 4 of a read byte
    r = 8'($urandom_range(0, 7));
    dataIn = r;
    startCond();
    writeByte(8'hA1, a);
    chk("t5_addr_ack", 32'(a), 32'd1);
    for (int i = 0; i < 3; i++) clockBit(1'b1, s);
    chk("t5_driving", 32'(sdaOe), 32'd1);
    resetN = 1'b0;
    tick(1);
    chk("t5_sdaOe", 32'(sdaOe), 32'd0);
    chk("t5_state", 32'(stateDbg), 32'(IDLE));
    chk("t5_dataOut", 32'(dataOut), 32'h00);
    chk("t5_we", 32'(writeEnable), 32'd0);
    chk("t5_rdEn", 32'(readEnable), 32'd1);
    chk("t5_rdReq", 32'(rdReq), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    expDataOut = 8'h00;
    resetN = 1'b1;
    tick(1);
    chk("t5_state_after", 32'(stateDbg), 32'(IDLE));
    stopCond();
    tick(4);
    drainWrites("t5");

    // Recovery write after reset
    startCond();
    writeByte(8'hA0, a);
    chk("rec_addr_ack", 32'(a), 32'd1);
    x = 8'($urandom);
    exp_q.push_back(x);
    expDataOut = x;
    writeByte(x, a);
    chk("rec_data_ack", 32'(a), 32'd1);
    stopCond();
    tick(4);
    drainWrites("rec");
    chk("rec_dataOut", 32'(dataOut), 32'(expDataOut));
    chk("strobe_overlap", 32'(overlapCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
